// File: rtl/lsu_bus_pkg.sv
// Shared load/store bus types: responder FSM states, byte-enable encodings
// and the lane/alignment legality check used by the data-RAM responder.
package lsu_bus_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_t;

  localparam logic [3:0] BE_BYTE0 = 4'b0001;
  localparam logic [3:0] BE_BYTE1 = 4'b0010;
  localparam logic [3:0] BE_BYTE2 = 4'b0100;
  localparam logic [3:0] BE_BYTE3 = 4'b1000;
  localparam logic [3:0] BE_HALF0 = 4'b0011;
  localparam logic [3:0] BE_HALF1 = 4'b1100;
  localparam logic [3:0] BE_WORD  = 4'b1111;

  function automatic logic be_legal(input logic [1:0] addr_lo, input logic [3:0] be);
    logic ok;
    ok = 1'b0;
    case (be)
      BE_BYTE0: ok = (addr_lo == 2'd0);
      BE_BYTE1: ok = (addr_lo == 2'd1);
      BE_BYTE2: ok = (addr_lo == 2'd2);
      BE_BYTE3: ok = (addr_lo == 2'd3);
      BE_HALF0: ok = (addr_lo == 2'd0);
      BE_HALF1: ok = (addr_lo == 2'd2);
      BE_WORD:  ok = (addr_lo == 2'd0);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_array_be.sv
// Single-port synchronous RAM, per-byte write enable, registered read.
// One-cycle read latency; read returns the pre-write contents on a store.
module mem_array_be #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < 4; b++) begin
          if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lsu_mem_resp.sv
// Data-RAM responder on the LSU bus: ack arrives WAIT_STATES+1 cycles after capture.
// Initiator holds the request until o_ack; inputs are ignored outside IDLE.
module lsu_mem_resp
  import lsu_bus_pkg::*;
#(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_be,
  output logic        o_ack,
  output logic [31:0] o_rdata,
  output logic        o_err,
  output logic        o_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  resp_state_t   state_q;
  logic [3:0]    cnt_q;
  logic          we_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;
  logic          err_q;
  logic          ack_q;
  logic          busy_q;

  logic          idle;
  logic          req_err;
  logic          cur_err;
  logic          cur_we;
  logic [AW-1:0] cur_idx;
  logic [31:0]   cur_wdata;
  logic [3:0]    cur_be;
  logic          enter_resp;
  logic          ram_en;
  logic [31:0]   ram_rdata;
  logic [31:0]   lane_mask;

  // BASE_ADDR is DEPTH*4-aligned, so range check reduces to matching the upper bits.
  assign req_err = (i_addr[31:AW+2] != BASE_ADDR[31:AW+2]) || !be_legal(i_addr[1:0], i_be);

  // With zero wait states the array is accessed on the capture edge itself.
  assign idle      = (state_q == IDLE);
  assign cur_err   = idle ? req_err            : err_q;
  assign cur_we    = idle ? i_we               : we_q;
  assign cur_idx   = idle ? i_addr[AW+1:2]     : idx_q;
  assign cur_wdata = idle ? i_wdata            : wdata_q;
  assign cur_be    = idle ? i_be               : be_q;

  assign enter_resp = idle ? (i_req && (WAIT_STATES == 0))
                           : ((state_q == WAIT) && (cnt_q == 4'd0));
  assign ram_en     = enter_resp && !cur_err && !rst;

  mem_array_be #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .en_i    (ram_en),
    .we_i    (cur_we),
    .be_i    (cur_be),
    .addr_i  (cur_idx),
    .wdata_i (cur_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_req) begin
            we_q    <= i_we;
            idx_q   <= i_addr[AW+1:2];
            wdata_q <= i_wdata;
            be_q    <= i_be;
            err_q   <= req_err;
            busy_q  <= 1'b1;
            if (WAIT_STATES == 0) begin
              state_q <= RESP;
              ack_q   <= 1'b1;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= RESP;
            ack_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lane_mask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};

  assign o_ack   = ack_q;
  assign o_err   = ack_q && err_q;
  assign o_busy  = busy_q;
  assign o_rdata = (ack_q && !we_q && !err_q) ? (ram_rdata & lane_mask) : 32'h0;

endmodule

// File: tb/tb_lsu_mem_resp.sv
// Scoreboard bench for lsu_mem_resp: two instances (1 and 3 wait states) driven in turn.
module tb_lsu_mem_resp;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  be    [2];
  logic        ack   [2];
  logic        err   [2];
  logic        busy  [2];
  logic [31:0] rdata [2];

  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int          inst;
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] mm [int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    lsu_mem_resp #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES((g == 0) ? 1 : 3)) dut (
      .clk     (clk),
      .rst     (rst),
      .i_req   (req[g]),
      .i_we    (we[g]),
      .i_addr  (addr[g]),
      .i_wdata (wdata[g]),
      .i_be    (be[g]),
      .o_ack   (ack[g]),
      .o_rdata (rdata[g]),
      .o_err   (err[g]),
      .o_busy  (busy[g])
    );

    always @(negedge clk) begin
      if (ack[g] === 1'b1) begin : mon
        exp_t e;
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_ack: inst %0d got ack, required none (cycle %0d)", g, cyc);
        end else begin
          e = sb.pop_front();
          chk("ack_inst", 64'(g), 64'(e.inst));
          chk("ack_cycle", 64'(cyc), 64'(e.due));
          chk("rdata", {32'h0, rdata[g]}, {32'h0, e.rdata});
          chk("err", {63'h0, err[g]}, {63'h0, e.err});
        end
      end
    end
  end

  // Legal iff be is a contiguous naturally-aligned group of 1, 2 or 4 lanes starting at addr%4.
  function automatic bit legal_be(input logic [31:0] a, input logic [3:0] b);
    int size;
    int lane;
    size = $countones(b);
    lane = 0;
    if (!(size == 1 || size == 2 || size == 4)) return 0;
    while (!b[lane]) lane++;
    if (b != 4'(((1 << size) - 1) << lane)) return 0;
    if (lane % size != 0) return 0;
    return int'(a % 4) == lane;
  endfunction

  task automatic model(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, output logic [31:0] rd, output logic e);
    longint      off;
    int          key;
    logic [31:0] word;
    off = longint'(a) - longint'(BASE);
    e   = !(off >= 0 && off < 4 * DEPTH) || !legal_be(a, b);
    rd  = 32'h0;
    if (!e) begin
      key  = k * DEPTH + int'(off / 4);
      word = mm.exists(key) ? mm[key] : 32'hx;
      for (int i = 0; i < 4; i++) begin
        if (b[i]) begin
          if (w) word[8*i +: 8] = d[8*i +: 8];
          else   rd[8*i +: 8]   = word[8*i +: 8];
        end
      end
      if (w) mm[key] = word;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge with the DUT in IDLE; returns in the cycle after the ack.
  task automatic issue(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input bit drop);
    logic [31:0] rd;
    logic        e;
    int          n0;
    bit          got;
    model(k, w, a, d, b, rd, e);
    n0 = cyc;
    sb.push_back('{k, rd, e, n0 + 1 + ws_of(k)});
    req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d; be[k] = b;
    @(negedge clk);
    chk("busy_idle", {63'h0, busy[k]}, 64'h0);
    if (drop) begin
      @(posedge clk); #1;
      req[k] = 1'b0; we[k] = ~w; addr[k] = $urandom; wdata[k] = $urandom; be[k] = 4'($urandom);
    end
    got = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      chk("busy_txn", {63'h0, busy[k]}, 64'h1);
      got = (ack[k] === 1'b1);
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL ack_timeout: inst %0d got no ack, required one by cycle %0d", k, n0 + 1 + ws_of(k));
      if (sb.size() != 0) void'(sb.pop_back());
    end
    @(posedge clk); #1;
    req[k] = 1'b0;
  endtask

  task automatic chk_quiet(input int k, input string name);
    chk(name, {28'h0, ack[k], err[k], busy[k], rdata[k]}, 64'h0);
  endtask

  // Store to word 1 aborted by reset: in the commit cycle (1 wait state) or second wait cycle (3).
  task automatic rst_abort(input int k);
    req[k] = 1'b1; we[k] = 1'b1; addr[k] = BASE + 32'd4; wdata[k] = 32'h1234_5678; be[k] = 4'hF;
    repeat ((ws_of(k) == 1) ? 1 : 2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; req[k] = 1'b0;
    @(negedge clk);
    chk_quiet(k, "post_rst_outputs");
    idle(2);
    issue(k, 1'b0, BASE + 32'd4, 32'h0, 4'hF, 1'b0);
  endtask

  task automatic directed(input int k);
    int idx [6] = '{0, 1, 2, 3, DEPTH - 2, DEPTH - 1};
    foreach (idx[i]) issue(k, 1'b1, BASE + 32'(4 * idx[i]), $urandom, 4'hF, 1'b0);
    issue(k, 1'b1, BASE, 32'hDEAD_BEEF, 4'hF, 1'b0);
    issue(k, 1'b0, BASE, 32'h0, 4'hF, 1'b0);
    issue(k, 1'b1, BASE + 32'd1, 32'h0000_5A00, 4'b0010, 1'b0);
    issue(k, 1'b0, BASE, 32'h0, 4'hF, 1'b0);
    issue(k, 1'b0, BASE + 32'd2, 32'h0, 4'b1100, 1'b0);
    issue(k, 1'b0, BASE - 32'd4, 32'h0, 4'hF, 1'b0);
    issue(k, 1'b0, BASE + 32'(4 * DEPTH), 32'h0, 4'hF, 1'b0);
    issue(k, 1'b1, 32'h0000_3000, 32'h1111_1111, 4'hF, 1'b0);
    issue(k, 1'b1, BASE + 32'd2, 32'h2222_2222, 4'hF, 1'b0);
    issue(k, 1'b1, BASE + 32'd1, 32'h3333_3333, 4'b0011, 1'b0);
    issue(k, 1'b1, BASE, 32'h4444_4444, 4'b0000, 1'b0);
    issue(k, 1'b1, BASE, 32'h5555_5555, 4'b0110, 1'b0);
    issue(k, 1'b0, BASE, 32'h0, 4'hF, 1'b0);
    issue(k, 1'b0, BASE + 32'(4 * (DEPTH - 1)) + 32'd3, 32'h0, 4'b1000, 1'b0);
    issue(k, 1'b0, BASE + 32'(4 * (DEPTH - 1)), 32'h0, 4'b0011, 1'b0);
  endtask

  task automatic random_run(input int k, input int n);
    int          sel;
    logic [31:0] a;
    logic [3:0]  b;
    for (int i = 0; i < n; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4)       a = BASE + 32'(4 * sel) + 32'($urandom_range(0, 3));
      else if (sel < 8)  a = BASE + 32'(4 * (DEPTH - 2 + (sel % 2))) + 32'($urandom_range(0, 3));
      else if (sel == 8) a = BASE - 32'd1 - 32'($urandom_range(0, 7));
      else               a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0: b = 4'b0001;
        1: b = 4'b0010;
        2: b = 4'b0100;
        3: b = 4'b1000;
        4: b = 4'b0011;
        5: b = 4'b1100;
        6: b = 4'b1111;
        default: b = 4'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      issue(k, 1'($urandom_range(0, 1)), a, $urandom, b, $urandom_range(0, 4) == 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; addr[k] = 32'h0; wdata[k] = 32'h0; be[k] = 4'h0;
    end
    idle(3);
    // A request presented during reset must be dropped.
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = BASE; wdata[0] = 32'hFFFF_FFFF; be[0] = 4'hF;
    @(posedge clk); #1;
    rst = 1'b0; req[0] = 1'b0;
    @(negedge clk);
    chk_quiet(0, "reset_outputs_ws1");
    chk_quiet(1, "reset_outputs_ws3");
    @(posedge clk); #1;

    for (int k = 0; k < 2; k++) begin
      directed(k);
      rst_abort(k);
      random_run(k, 40);
    end

    idle(3);
    chk("sb_empty", 64'(sb.size()), 64'h0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
